stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Multi-register stack transfer engine for the core's execute stage.
- Takes a pre-decoded push/pop register mask (bit order AW, CW, DW, BW, SP, BP, IX, IY, DS1, PSW, PS, SS, DS0, PC, MODRM, IMM) and the current SP.
- Issues one stack memory request per set bit to the bus unit over a valid/ready handshake.
- Commits the final SP once all requests complete.
- Generalises the fixed 16-entry mask to a parametrised mask width, address width and step size, and adds direction mode, pop-discard slots and abort.

Parameters:
- MASK_W, 16, number of mask bits / transferable slots.
- ADDR_W, 16, SP and stack offset width; arithmetic is modulo 2^ADDR_W.
- STEP, 2, bytes per slot added to or subtracted from SP.
- SP_INDEX, 4, slot index of SP; on push, the SP value captured at start is flagged for that slot.
- POP_DISCARD, 16'h0010, per-slot mask; popped slots in this mask use an address and SP step, but their data is marked discard.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a sequence; accepted only in IDLE
- dir  in  1  0 = push, 1 = pop
- mask  in  MASK_W  slots to transfer
- sp_in  in  ADDR_W  SP value at start
- abort  in  1  cancel the sequence in progress
- busy  out  1  high in REQ and DONE
- req_valid  out  1  stack request pending
- req_ready  in  1  bus unit accepts the request
- req_write  out  1  1 = push (write), 0 = pop (read)
- req_addr  out  ADDR_W  stack offset of this slot
- req_index  out  $clog2(MASK_W)  slot being transferred
- req_sp_orig  out  1  push of SP_INDEX; data source is the SP captured at start
- req_discard  out  1  pop of a POP_DISCARD slot; read data must not be written back
- sp_out  out  ADDR_W  final SP
- sp_we  out  1  one-cycle commit strobe for sp_out
- done  out  1  one-cycle completion pulse, coincident with sp_we

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - All outputs are 0; internal mask and SP registers are cleared.
- States are IDLE, REQ and DONE.
- IDLE:
  - start=1 latches mask, dir and sp_in.
  - With mask != 0, the next state is REQ.
  - With mask == 0, the next state is DONE; no requests are issued and sp_out = sp_in.
- REQ, slot selection:
  - Push selects the lowest set bit remaining.
  - Pop selects the highest set bit remaining.
- REQ, outputs:
  - req_valid=1; req_index is the selected slot.
  - Push: req_write=1, req_addr = SP_cur − STEP.
  - Pop: req_write=0, req_addr = SP_cur.
  - req_sp_orig and req_discard are decoded combinationally from req_index and dir.
- REQ, handshake:
  - Outputs hold stable while req_valid && !req_ready.
  - On req_valid && req_ready, the slot's bit is cleared and SP_cur updates: −STEP for push, +STEP for pop, mod 2^ADDR_W.
  - If no bits remain after the update, the next state is DONE; otherwise stay in REQ and present the next slot the following cycle with no bubble.
- DONE:
  - done=1 and sp_we=1 for exactly one cycle, with sp_out = SP_cur.
  - Next state is IDLE; busy drops in the same cycle state returns to IDLE.
- Throughput is one slot per cycle when req_ready is held high.
- Latency from start to done is popcount(mask)+1 cycles (1 cycle for an empty mask).
- Abort:
  - In REQ or DONE, abort=1 forces IDLE next cycle.
  - req_valid drops, sp_we and done do not assert, and the caller's SP stays unchanged.
  - A handshake occurring in the same cycle as abort still counts as accepted on the bus, but SP is not committed.
- start while busy is ignored; start and abort together in IDLE causes abort to win (no sequence starts).
- SP wrap: push from sp_in=0x0000 produces req_addr=0xFFFE with no error flag; pop wraps 0xFFFE to 0x0000.
- Mask bits at or above MASK_W do not exist; a full-ones mask yields MASK_W requests.

Test Plan:
1. Push, mask=0x00FF, sp_in=0x0100, req_ready=1:
   - Required: 8 requests, index 0..7, addr 0x00FE down to 0x00F0.
   - Required: index 4 has req_sp_orig=1.
   - Required: done and sp_we in the 9th cycle after start, with sp_out=0x00F0.
2. Pop, mask=0x00FF, sp_in=0x00F0:
   - Required: index 7..0, addr 0x00F0 up to 0x00FE.
   - Required: index 4 has req_discard=1.
   - Required: sp_out=0x0100.
3. Backpressure, push mask=0x0005, sp_in=0x0010, req_ready low for 3 cycles on the first slot:
   - Required: addr 0x000E and index 0 held stable for those cycles, then index 2 at 0x000C.
   - Required: sp_out=0x000C.
4. Empty mask, start with mask=0:
   - Required: no req_valid; done and sp_we the next cycle with sp_out=sp_in.
5. Wrap, push mask=0x0003, sp_in=0x0000:
   - Required: addr 0xFFFE then 0xFFFC; sp_out=0xFFFC.
6. Abort, and reset mid-sequence:
   - Abort after the 2nd handshake of a mask=0x000F push: required no done and no sp_we; busy=0 the next cycle; a new start is accepted afterwards.
   - reset_n low mid-REQ: required all outputs immediately 0.

Source files
------------

// File: rtl/stack_sequencer.sv
// Multi-register stack transfer engine: walks a push/pop slot mask, issues one
// stack request per set bit over valid/ready, then commits the final SP.
module stack_sequencer #(
  parameter int                MASK_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                STEP        = 2,
  parameter int                SP_INDEX    = 4,
  parameter logic [MASK_W-1:0] POP_DISCARD = 16'h0010,
  localparam int               IDX_W       = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dir,
  input  logic [MASK_W-1:0] mask,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              abort,
  output logic              busy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [IDX_W-1:0]  req_index,
  output logic              req_sp_orig,
  output logic              req_discard,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] sp_q, sp_d;

  logic [IDX_W-1:0]  sel;
  logic [MASK_W-1:0] mask_clr;

  // Push walks low-to-high, pop high-to-low: the later hit in each loop wins.
  always_comb begin
    sel = '0;
    if (dir_q) begin
      for (int i = 0; i < MASK_W; i++)
        if (mask_q[i]) sel = IDX_W'(i);
    end else begin
      for (int i = MASK_W - 1; i >= 0; i--)
        if (mask_q[i]) sel = IDX_W'(i);
    end
  end

  assign mask_clr = mask_q & ~(MASK_W'(1) << sel);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    dir_d       = dir_q;
    sp_d        = sp_q;
    busy        = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_index   = '0;
    req_sp_orig = 1'b0;
    req_discard = 1'b0;
    sp_out      = '0;
    sp_we       = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d  = mask;
          dir_d   = dir;
          sp_d    = sp_in;
          state_d = (mask == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        busy        = 1'b1;
        req_valid   = 1'b1;
        req_write   = !dir_q;
        req_addr    = dir_q ? sp_q : sp_q - STEP_V;
        req_index   = sel;
        req_sp_orig = !dir_q && (sel == IDX_W'(SP_INDEX));
        req_discard = dir_q && POP_DISCARD[sel];
        if (req_ready) begin
          mask_d = mask_clr;
          sp_d   = dir_q ? sp_q + STEP_V : sp_q - STEP_V;
          if (mask_clr == '0) state_d = DONE;
        end
        // A same-cycle handshake is still taken by the bus; only the commit is lost.
        if (abort) state_d = IDLE;
      end
      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
        if (!abort) begin
          done   = 1'b1;
          sp_we  = 1'b1;
          sp_out = sp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dir_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
      sp_q    <= sp_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed scenarios plus randomized sequences
// checked against a slot-list model built from the mask, direction and SP.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, dir = 1'b0, abort = 1'b0, req_ready = 1'b0;
  logic [15:0] mask = '0, sp_in = '0;
  logic        busy, req_valid, req_write, req_sp_orig, req_discard, sp_we, done;
  logic [15:0] req_addr, sp_out;
  logic [3:0]  req_index;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic [15:0] addr;
  } exp_t;

  stack_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .mask(mask),
    .sp_in(sp_in), .abort(abort), .busy(busy), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_index(req_index), .req_sp_orig(req_sp_orig), .req_discard(req_discard),
    .sp_out(sp_out), .sp_we(sp_we), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {21'd0, busy, req_valid, req_write, req_addr, req_index,
            req_sp_orig, req_discard, sp_out, sp_we, done};
  endfunction

  // Model: expand mask into the ordered slot list with addresses, then follow
  // the DUT cycle by cycle, consuming one slot per observed handshake.
  task automatic run_seq(input logic d, input logic [15:0] m, input logic [15:0] sp,
                         input int pct, input int hold, input bit noise);
    exp_t        q[$];
    logic [15:0] rem = m;
    logic [15:0] s = sp;
    int          n = 0;
    int          cyc = 0;
    bit          fin = 0;
    while (rem != 0) begin
      int k = -1;
      for (int i = 0; i < 16; i++)
        if (rem[i] && (d || k < 0)) k = i;
      q.push_back('{k, d ? s : s - 16'd2});
      s = d ? s + 16'd2 : s - 16'd2;
      rem[k] = 1'b0;
      n++;
    end
    @(negedge clk);
    start = 1'b1; dir = d; mask = m; sp_in = sp; req_ready = 1'b0; abort = 1'b0;
    #1 chk("idle_busy", busy, 0);
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) begin
        mask = 16'($urandom); dir = 1'($urandom_range(1)); sp_in = 16'($urandom);
      end
      req_ready = (cyc <= hold) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      if (req_valid) begin
        chk("req_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("req_index", req_index, q[0].idx);
          chk("req_addr", req_addr, q[0].addr);
          chk("req_write", req_write, !d);
          chk("req_sp_orig", req_sp_orig, !d && q[0].idx == 4);
          chk("req_discard", req_discard, d && q[0].idx == 4);
          if (req_ready) void'(q.pop_front());
        end
      end
      if (done) begin
        fin = 1;
        chk("done_left", q.size(), 0);
        chk("sp_out", sp_out, s);
        chk("sp_we", sp_we, 1);
        if (pct == 100 && hold == 0) chk("latency", cyc, n + 1);
      end
    end
    chk("finished", fin, 1);
    @(negedge clk);
    start = 1'b0; req_ready = 1'b0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  initial begin
    #1 chk("reset_outs", all_out(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_seq(1'b0, 16'h00FF, 16'h0100, 100, 0, 0);
    run_seq(1'b1, 16'h00FF, 16'h00F0, 100, 0, 0);
    run_seq(1'b0, 16'h0005, 16'h0010, 100, 3, 0);
    run_seq(1'b0, 16'h0000, 16'h1234, 100, 0, 0);
    run_seq(1'b0, 16'h0003, 16'h0000, 100, 0, 0);
    run_seq(1'b1, 16'h0003, 16'hFFFE, 100, 0, 0);
    run_seq(1'b0, 16'hFFFF, 16'h8000, 100, 0, 0);

    // Abort after the second handshake of a push
    @(negedge clk);
    start = 1'b1; dir = 1'b0; mask = 16'h000F; sp_in = 16'h0200; req_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      start = 1'b0;
      #1 chk("ab_valid", req_valid, 1);
    end
    @(negedge clk);
    abort = 1'b1; req_ready = 1'b0;
    #1 chk("ab_done", done, 0);
    chk("ab_sp_we", sp_we, 0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("ab_busy", busy, 0);
    chk("ab_valid_low", req_valid, 0);
    chk("ab_done2", done, 0);
    run_seq(1'b0, 16'h0009, 16'h0040, 100, 0, 0);

    // Abort while in DONE suppresses the commit
    @(negedge clk);
    start = 1'b1; mask = 16'h0000; sp_in = 16'h5555;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    #1 chk("abd_done", done, 0);
    chk("abd_sp_we", sp_we, 0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abd_busy", busy, 0);

    // Start together with abort in IDLE does nothing
    @(negedge clk);
    start = 1'b1; abort = 1'b1; mask = 16'h0003;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1 chk("sa_busy", busy, 0);
    chk("sa_valid", req_valid, 0);

    // Reset mid-REQ clears every output immediately
    @(negedge clk);
    start = 1'b1; dir = 1'b0; mask = 16'h000F; sp_in = 16'h0300; req_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1 chk("rst_pre_valid", req_valid, 1);
    reset_n = 1'b0;
    #1 chk("rst_outs", all_out(), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 40; t++) begin
      logic [15:0] m;
      m = (t % 10 == 9) ? 16'hFFFF : 16'($urandom & $urandom);
      run_seq(1'($urandom_range(1)), m, 16'($urandom), $urandom_range(30, 100), 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
